// File: rtl/sized_data_memory_pkg.sv
// Shared types and width helpers for the sized data memory and its lane aligner.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // ceil(log2(v)); 1 maps to 0
  function automatic int log2c(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for sized accesses: store merge, load extract/extend, alignment check.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  size_e                 size,
  input  logic [2:0]            off,
  input  logic                  sgn,
  input  logic [DATA_W-1:0]     raw,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     wword,
  output logic [DATA_W-1:0]     rdata,
  output logic                  misalign
);
  localparam int NB = DATA_W / 8;

  logic [3:0]        sz_b, off4, end4;
  logic [DATA_W-1:0] wsh, rsh;
  logic [NB-1:0]     top_hit;
  logic              sbit;

  assign sz_b = 4'd1 << size;
  assign off4 = {1'b0, off};
  assign end4 = off4 + sz_b;
  assign wsh  = wdata << {off, 3'b000};
  assign rsh  = raw >> {off, 3'b000};
  assign sbit = |top_hit;

  assign misalign = (sz_b > 4'(NB)) || ((off & 3'(sz_b - 4'd1)) != 3'd0);

  for (genvar i = 0; i < NB; i++) begin : g_lane
    localparam logic [3:0] LI = 4'(i);
    assign be[i]            = (LI >= off4) && (LI < end4);
    assign wword[8*i +: 8]  = be[i] ? wsh[8*i +: 8] : raw[8*i +: 8];
    // top_hit picks the MSB of the highest extracted lane as the sign
    assign top_hit[i]       = ((LI + 4'd1) == sz_b) & rsh[8*i+7];
    assign rdata[8*i +: 8]  = (LI < sz_b) ? rsh[8*i +: 8] : {8{sgn & sbit}};
  end

endmodule

// File: rtl/sized_data_memory.sv
// Byte-addressed data memory with sized loads/stores, registered response and clear sweep.
module sized_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic              clear_start,
  output logic              busy
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = log2c(NB);
  localparam int IDX_B = log2c(DEPTH);
  localparam int IDX_W = (IDX_B > 0) ? IDX_B : 1;

  state_e              state, state_nx;
  logic [IDX_W-1:0]    cnt, cnt_nx, idx;
  logic [2:0]          off;
  logic                accept, err, range_err, misalign, st_we, clr_we;
  logic [NB-1:0]       be;
  logic [DATA_W-1:0]   raw, wword, ldata;
  logic [DATA_W-1:0]   words [DEPTH];

  assign off       = 3'(req_addr & ADDR_W'(NB - 1));
  assign idx       = IDX_W'((req_addr >> OFF_W) & ADDR_W'(DEPTH - 1));
  assign range_err = (req_addr >> (OFF_W + IDX_B)) != '0;
  assign raw       = words[idx];
  assign err       = range_err | misalign;
  assign accept    = req_valid & req_ready;
  assign st_we     = accept & req_we & ~err & (|be);

  dmem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size     (size_e'(req_size)),
    .off      (off),
    .sgn      (req_signed),
    .raw      (raw),
    .wdata    (req_wdata),
    .be       (be),
    .wword    (wword),
    .rdata    (ldata),
    .misalign (misalign)
  );

  // Storage is deliberately outside reset; each word powers up holding its own index.
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic [DATA_W-1:0] q = DATA_W'(w);
    always_ff @(posedge clk) begin
      if (clr_we && cnt == IDX_W'(w))      q <= '0;
      else if (st_we && idx == IDX_W'(w))  q <= wword;
    end
    assign words[w] = q;
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    req_ready = 1'b0;
    busy      = 1'b0;
    clr_we    = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = ~clear_start;
        if (clear_start) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        cnt_nx = cnt + IDX_W'(1);
        if (cnt == IDX_W'(DEPTH - 1)) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rsp_valid <= accept;
      rsp_err   <= accept & err;
      rsp_rdata <= (accept && !req_we && !err) ? ldata : '0;
    end
  end

endmodule

// File: tb/tb_sized_data_memory.sv
// Self-checking bench: directed vector table, randomized traffic vs. byte-array model, clear/reset corners.
module tb_sized_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic        rsp_valid, rsp_err, clear_start, busy;

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned mem_b [512];

  sized_data_memory #(.DATA_W(64), .DEPTH(64), .ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .clear_start(clear_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    bit [1:0]    sz;
    bit          sg;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] erd;
    bit          eer;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Memory viewed as a flat byte array; a word-i init means byte 8*i holds i.
  function automatic void model(input bit we, input bit [1:0] sz, input bit sg,
                                input logic [63:0] a, input logic [63:0] wd,
                                output logic [63:0] rd, output bit er);
    int n;
    n  = 1 << sz;
    rd = '0;
    er = (a >= 64'd512) || ((a % 64'(n)) != 0);
    if (er) return;
    for (int k = 0; k < n; k++) begin
      if (we) mem_b[int'(a) + k] = wd[8*k +: 8];
      else    rd[8*k +: 8] = mem_b[int'(a) + k];
    end
    if (!we && sg && rd[8*n-1])
      for (int k = n; k < 8; k++) rd[8*k +: 8] = 8'hFF;
  endfunction

  task automatic do_req(input bit we, input bit [1:0] sz, input bit sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        input logic [63:0] erd, input bit eer, input string nm);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    #1 chk({nm, ".ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, ".rdata"}, rsp_rdata, erd);
    chk({nm, ".err"}, 64'(rsp_err), 64'(eer));
  endtask

  task automatic idle_cycle(input string nm);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1 chk({nm, ".nopulse"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic model_req(input bit we, input bit [1:0] sz, input bit sg,
                           input logic [63:0] a, input logic [63:0] wd, input string nm);
    logic [63:0] rd;
    bit er;
    model(we, sz, sg, a, wd, rd, er);
    do_req(we, sz, sg, a, wd, rd, er, nm);
  endtask

  vec_t vt[$];

  initial begin
    int bcnt;
    bit bad_ready, bad_vld;

    for (int i = 0; i < 512; i++) mem_b[i] = (i % 8 == 0) ? 8'(i / 8) : 8'h00;

    vt.push_back('{1'b0, 2'd3, 1'b0, 64'h18, 64'h0, 64'h3, 1'b0});
    vt.push_back('{1'b1, 2'd0, 1'b0, 64'h0B, 64'h55AB, 64'h0, 1'b0});
    vt.push_back('{1'b0, 2'd3, 1'b0, 64'h08, 64'h0, 64'h00000000AB000001, 1'b0});
    vt.push_back('{1'b0, 2'd0, 1'b1, 64'h0B, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0});
    vt.push_back('{1'b0, 2'd0, 1'b0, 64'h0B, 64'h0, 64'hAB, 1'b0});
    vt.push_back('{1'b1, 2'd1, 1'b0, 64'h03, 64'h1234, 64'h0, 1'b1});
    vt.push_back('{1'b0, 2'd3, 1'b0, 64'h00, 64'h0, 64'h0, 1'b0});
    vt.push_back('{1'b0, 2'd3, 1'b0, 64'h200, 64'h0, 64'h0, 1'b1});
    vt.push_back('{1'b0, 2'd1, 1'b1, 64'h0A, 64'h0, 64'hFFFFFFFFFFFFAB00, 1'b0});
    vt.push_back('{1'b1, 2'd2, 1'b0, 64'h14, 64'h11111111DEADBEEF, 64'h0, 1'b0});
    vt.push_back('{1'b0, 2'd2, 1'b0, 64'h10, 64'h0, 64'h2, 1'b0});
    vt.push_back('{1'b0, 2'd2, 1'b1, 64'h14, 64'h0, 64'hFFFFFFFFDEADBEEF, 1'b0});
    vt.push_back('{1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 64'hDEADBEEF00000002, 1'b0});
    vt.push_back('{1'b0, 2'd3, 1'b0, 64'h1F8, 64'h0, 64'h3F, 1'b0});
    vt.push_back('{1'b0, 2'd2, 1'b0, 64'h02, 64'h0, 64'h0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 1'b0, 64'h8000000000000008, 64'h0, 64'h0, 1'b1});
    vt.push_back('{1'b0, 2'd0, 1'b0, 64'h1FF, 64'h0, 64'h0, 1'b0});

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; clear_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(rsp_valid), 64'd0);
    chk("rst.err", 64'(rsp_err), 64'd0);
    chk("rst.rdata", rsp_rdata, 64'd0);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      logic [63:0] dummy;
      bit de;
      model(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, dummy, de);
      do_req(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, vt[i].erd, vt[i].eer,
             $sformatf("vec%0d", i));
    end
    idle_cycle("vec_end");

    for (int i = 0; i < 400; i++) begin
      bit we, sg;
      bit [1:0] sz;
      logic [63:0] a, wd;
      int r;
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      r  = $urandom_range(0, 19);
      if (r == 0) a = {$urandom, $urandom} | 64'h0000_1000_0000_0000;
      else begin
        a = 64'($urandom_range(0, 511));
        if (r < 15) a = a & ~64'((1 << sz) - 1);
      end
      model_req(we, sz, sg, a, wd, $sformatf("rnd%0d", i));
      if ($urandom_range(0, 7) == 0) idle_cycle($sformatf("rnd%0d", i));
    end
    idle_cycle("rnd_end");

    // Clear colliding with a request: clear wins, sweep lasts DEPTH cycles.
    @(negedge clk);
    clear_start = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h18;
    #1 chk("clr.ready_collide", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("clr.not_accepted", 64'(rsp_valid), 64'd0);
    chk("clr.busy_first", 64'(busy), 64'd1);
    @(negedge clk);
    clear_start = 1'b0; req_valid = 1'b0;
    bcnt = 1; bad_ready = 1'b0; bad_vld = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      bcnt++;
      if (req_ready) bad_ready = 1'b1;
      if (rsp_valid) bad_vld = 1'b1;
    end
    chk("clr.busy_cycles", 64'(bcnt), 64'd64);
    chk("clr.ready_low", 64'(bad_ready), 64'd0);
    chk("clr.no_rsp", 64'(bad_vld), 64'd0);
    for (int i = 0; i < 512; i++) mem_b[i] = 8'h00;
    model_req(1'b0, 2'd3, 1'b0, 64'h18, 64'h0, "clr.load18");
    model_req(1'b0, 2'd3, 1'b0, 64'h1F8, 64'h0, "clr.load1f8");

    // Reset with a response pending drops it immediately.
    model_req(1'b1, 2'd3, 1'b0, 64'h28, 64'h5, "pre.w5");
    model_req(1'b1, 2'd3, 1'b0, 64'h140, 64'h28, "pre.w40");
    model_req(1'b0, 2'd3, 1'b0, 64'h140, 64'h0, "pre.r40");
    #2 rst = 1'b1;
    #1 chk("rst.rsp_drop", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset ten sweep cycles into a clear aborts it.
    @(negedge clk);
    clear_start = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clear_start = 1'b0;
    repeat (10) @(posedge clk);
    #1 chk("abort.busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    chk("abort.busy_drop", 64'(busy), 64'd0);
    chk("abort.valid_drop", 64'(rsp_valid), 64'd0);
    chk("abort.ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 80; i++) mem_b[i] = 8'h00;
    do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'h0, 64'h0, 1'b0, "abort.word5");
    do_req(1'b0, 2'd3, 1'b0, 64'h140, 64'h0, 64'h28, 1'b0, "abort.word40");
    for (int i = 0; i < 40; i++)
      model_req(1'b0, 2'd3, 1'b0, 64'(i * 8), 64'h0, $sformatf("abort.scan%0d", i));
    idle_cycle("done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
